// File: rtl/kernel_bram_ctrl.sv
// kernel_bram_ctrl: sequences weight loading into and arbitrates conv reads from the single-port kernel BRAM
module kernel_bram_ctrl #(
    parameter int KERNEL_WEIGHT_BITS     = 6,
    parameter int KERNEL_SIZE            = 3,
    parameter int IN_CHANNELS            = 6,
    parameter int OUT_CHANNELS           = 6,
    parameter int DATA_WIDTH             = KERNEL_WEIGHT_BITS * OUT_CHANNELS,
    parameter int TOTAL_KERNEL_POSITIONS = IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
    parameter int ADDR_WIDTH             = $clog2(TOTAL_KERNEL_POSITIONS),
    parameter int READ_LATENCY           = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  load_done,
    output logic                  weights_ready,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_data_in,
    input  logic [DATA_WIDTH-1:0] bram_data_out
);
    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TOTAL_KERNEL_POSITIONS - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(TOTAL_KERNEL_POSITIONS);
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    load_done_q, load_done_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic                    wr_fire, rd_fire, in_range, last_wr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            load_done_q <= 1'b0;
            pipe_q      <= '0;
        end else begin
            cnt_q       <= cnt_d;
            load_done_q <= load_done_d;
            pipe_q      <= pipe_d;
        end
    end
    always_comb begin
        state_d = cfg_start ? LOAD : last_wr ? READY : state_q;
    end
    // cfg_start masks both handshakes so a restart never overlaps an access
    always_comb begin
        wr_ready      = state_q == LOAD && !cfg_start;
        rd_ready      = state_q == READY && rd_req && !cfg_start;
        weights_ready = state_q == READY;
        in_range      = {1'b0, rd_addr} < DEPTH;
        wr_fire       = wr_ready && wr_valid;
        rd_fire       = rd_ready && in_range;
        rd_err        = rd_ready && !in_range;
        last_wr       = wr_fire && cnt_q == LAST_ADDR;
        bram_en       = wr_fire || rd_fire;
        bram_we       = wr_fire;
        bram_addr     = wr_fire ? cnt_q : rd_fire ? rd_addr : '0;
        bram_data_in  = wr_fire ? wr_data : '0;
        cnt_d         = cfg_start ? '0 : !wr_fire ? cnt_q : last_wr ? '0 : cnt_q + 1'b1;
        load_done_d   = last_wr;
        pipe_d        = READ_LATENCY'({pipe_q, rd_fire});
    end
    assign load_done = load_done_q;
    assign rd_valid  = pipe_q[READ_LATENCY-1];
    assign rd_data   = bram_data_out;
endmodule

// File: doc/kernel_bram_ctrl.md
Name: kernel_bram_ctrl

Overview:
- Sequences and arbitrates the single-port kernel-weight BRAM (TOTAL_KERNEL_POSITIONS words of DATA_WIDTH bits).
- Owns the BRAM control lines. Serves two clients that never touch the BRAM directly:
  - a weight loader that streams words in sequentially (valid/ready);
  - the convolution engine, which issues random-address reads.
- Lock-out FSM: reads are accepted only after a complete load; writes only during load.

Parameters:
- KERNEL_WEIGHT_BITS, 6, bits per weight
- KERNEL_SIZE, 3, kernel edge length
- IN_CHANNELS, 6, input channels
- OUT_CHANNELS, 6, output channels (weights packed per word)
- DATA_WIDTH, KERNEL_WEIGHT_BITS*OUT_CHANNELS, BRAM word width
- TOTAL_KERNEL_POSITIONS, IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE, BRAM depth
- ADDR_WIDTH, $clog2(TOTAL_KERNEL_POSITIONS), address width
- READ_LATENCY, 1, BRAM en-to-data_out cycles; legal values 1 or 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_start  in  1  pulse: invalidate weights, begin (re)load at address 0
- wr_valid  in  1  loader word valid
- wr_ready  out  1  controller accepts loader word
- wr_data  in  DATA_WIDTH  loader word
- load_done  out  1  one-cycle pulse after the last word is written
- weights_ready  out  1  high while in READY
- rd_req  in  1  conv read request
- rd_addr  in  ADDR_WIDTH  conv read address
- rd_ready  out  1  read request accepted this cycle
- rd_valid  out  1  rd_data valid
- rd_data  out  DATA_WIDTH  read word
- rd_err  out  1  one-cycle pulse: rd_addr >= TOTAL_KERNEL_POSITIONS
- bram_en, bram_we  out  1 each  BRAM enable / write enable
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_data_in  out  DATA_WIDTH  BRAM write data
- bram_data_out  in  DATA_WIDTH  BRAM read data

Behaviour:
- Reset (async assert, sync release):
  - state=EMPTY, write counter=0.
  - All outputs 0: wr_ready, load_done, weights_ready, rd_ready, rd_valid, rd_err, bram_en, bram_we, bram_addr, bram_data_in.
  - Read-latency pipeline cleared. Any in-flight read or load is discarded.
- EMPTY:
  - Ignores wr_valid and rd_req.
  - cfg_start -> LOAD.
- LOAD:
  - wr_ready=1 combinationally.
  - On wr_valid&wr_ready, same cycle: bram_en=1, bram_we=1, bram_addr=counter, bram_data_in=wr_data; counter increments.
  - When the word at address TOTAL_KERNEL_POSITIONS-1 is written: next cycle state=READY and load_done=1 for exactly one cycle. Counter returns to 0.
  - rd_req ignored: rd_ready=0, no rd_err.
- READY:
  - weights_ready=1, wr_ready=0.
  - rd_ready = rd_req, combinational.
  - In-range accepted read: bram_en=1, bram_we=0, bram_addr=rd_addr in the same cycle. rd_valid pulses exactly READ_LATENCY cycles later, with rd_data=bram_data_out (passthrough, no extra register).
  - Back-to-back reads every cycle are supported: throughput 1 word/cycle.
  - Out-of-range rd_addr: rd_ready=1, rd_err=1 the same cycle, no BRAM access, no rd_valid.
- cfg_start in any state: counter=0 next cycle, state=LOAD, weights_ready drops next cycle.
  - cfg_start outranks same-cycle wr_valid and rd_req: neither is accepted.
  - Reads already in flight still deliver rd_valid.
- bram_en=0 whenever no access is granted.
- Write accepted on the last address at the same time as cfg_start: cfg_start wins; no load_done.

Test Plan:
- Reset value check (defaults: DATA_WIDTH=36, depth=54, ADDR_WIDTH=6): hold rst_n=0 mid-load after 10 writes -> all outputs 0. After release, rd_req gives rd_ready=0; wr_valid gives wr_ready=0 until cfg_start.
- Full load with continuous wr_valid, data=address+100 -> 54 writes to addr 0..53, one per cycle. load_done pulses once, on the cycle after the addr-53 write. weights_ready=1 thereafter.
- Load with random wr_valid gaps (~50% duty) -> no address skipped or repeated. Readback of all 54 addresses returns address+100.
- READ_LATENCY=1 and =2: back-to-back reads of addr 5,6,53 -> rd_valid on 3 consecutive cycles, starting 1 (resp. 2) cycles after the first request. Data 105,106,153.
- rd_addr=54 and 63 in READY -> rd_ready=1, rd_err pulse, bram_en=0, no rd_valid.
- cfg_start in READY, same cycle as rd_req addr 3 -> read not accepted; weights_ready=0 next cycle. Reload with data=address+200 -> readback of addr 3 returns 203.
